// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: load-use and mul/div scoreboard stalls, branch flushes, memory freezes.
// Optional performance counters are compiled in with `define HAZARD_PERF_EN.
module hazard_ctrl #(
   parameter int REG_W  = 5,
   parameter int MD_LAT = 8
`ifdef HAZARD_PERF_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_regwrite,
   input  logic             id_is_md,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_regwrite,
   input  logic             ex_memread,
   input  logic             md_start,
   input  logic [REG_W-1:0] md_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_stall,
`ifdef HAZARD_PERF_EN
   input  logic             perf_clr,
   output logic [CNT_W-1:0] perf_lu_cnt,
   output logic [CNT_W-1:0] perf_md_cnt,
   output logic [CNT_W-1:0] perf_flush_cnt,
`endif
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             md_busy,
   output logic             md_wb,
   output logic [REG_W-1:0] md_rd_q
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0]       CNT_INIT = 8'(MD_LAT - 1);
   localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};

   state_t           state_q, state_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [REG_W-1:0] md_rd_d;
   logic             run_q, run_d;

   logic issue_s;
   logic lu_s;
   logic raw_s;
   logic waw_s;
   logic mdh_s;

   // State, latency counter, scoreboard entry and run flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         md_rd_q <= REG_ZERO;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         md_rd_q <= md_rd_d;
         run_q   <= run_d;
      end
   end

   // Mul/div scoreboard next state; the counter keeps running through memory freezes
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      md_rd_d = md_rd_q;
      run_d   = 1'b1;
      issue_s = md_start & ~mem_stall;
      case (state_q)
         IDLE: begin
            if (issue_s) begin
               state_d = BUSY;
               cnt_d   = CNT_INIT;
               md_rd_d = md_rd;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (cnt_q == 8'd1) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         DONE: begin
            if (issue_s) begin
               state_d = BUSY;
               cnt_d   = CNT_INIT;
               md_rd_d = md_rd;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign md_busy = (state_q != IDLE);
   assign md_wb   = (state_q == DONE);

   // Hazard detection; x0 never creates a dependency
   always_comb begin
      lu_s  = ex_memread & ex_regwrite & (ex_rd != REG_ZERO) &
              ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
      raw_s = (md_rd_q != REG_ZERO) &
              ((id_rs1_used & (id_rs1 == md_rd_q)) | (id_rs2_used & (id_rs2 == md_rd_q)));
      waw_s = (md_rd_q != REG_ZERO) & id_regwrite & (id_rd == md_rd_q);
      // Held through DONE: the regfile is not write-through, so the consumer leaves ID after md_wb
      mdh_s = md_busy & (raw_s | waw_s | id_is_md);
   end

   // Pipeline control, highest priority first: not running, freeze, flush, stall, normal
   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      if (!run_q || mem_stall) begin
         pc_en = 1'b0;
      end else if (ex_branch_taken) begin
         pc_en       = 1'b1;
         ifid_en     = 1'b1;
         idex_en     = 1'b1;
         exmem_en    = 1'b1;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (lu_s || mdh_s) begin
         idex_en     = 1'b1;
         exmem_en    = 1'b1;
         idex_bubble = 1'b1;
      end else begin
         pc_en    = 1'b1;
         ifid_en  = 1'b1;
         idex_en  = 1'b1;
         exmem_en = 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] perf_lu_q, perf_lu_d;
   logic [CNT_W-1:0] perf_md_q, perf_md_d;
   logic [CNT_W-1:0] perf_flush_q, perf_flush_d;
   logic             live_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      if (en && (v != {CNT_W{1'b1}})) begin
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         return v;
      end
   endfunction

   // Counter updates; frozen cycles are not counted
   always_comb begin
      live_s       = run_q & ~mem_stall;
      perf_lu_d    = sat_inc(perf_lu_q, live_s & ~ex_branch_taken & lu_s);
      perf_md_d    = sat_inc(perf_md_q, live_s & ~ex_branch_taken & mdh_s);
      perf_flush_d = sat_inc(perf_flush_q, live_s & ex_branch_taken);
      if (perf_clr) begin
         perf_lu_d    = {CNT_W{1'b0}};
         perf_md_d    = {CNT_W{1'b0}};
         perf_flush_d = {CNT_W{1'b0}};
      end else begin
         live_s = live_s;
      end
   end

   // Performance counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_lu_q    <= {CNT_W{1'b0}};
         perf_md_q    <= {CNT_W{1'b0}};
         perf_flush_q <= {CNT_W{1'b0}};
      end else begin
         perf_lu_q    <= perf_lu_d;
         perf_md_q    <= perf_md_d;
         perf_flush_q <= perf_flush_d;
      end
   end

   assign perf_lu_cnt    = perf_lu_q;
   assign perf_md_cnt    = perf_md_q;
   assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: combinational vector table plus mul/div, freeze and reset sequences.
module tb_hazard_ctrl;

   localparam int REG_W  = 5;
   localparam int MD_LAT = 8;

   // {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble}
   localparam logic [5:0] NORM   = 6'b111100;
   localparam logic [5:0] STALL  = 6'b001101;
   localparam logic [5:0] FLUSH  = 6'b111111;
   localparam logic [5:0] FREEZE = 6'b000000;

   logic             clk;
   logic             rst_n;
   logic [REG_W-1:0] id_rs1, id_rs2, id_rd, ex_rd, md_rd;
   logic             id_rs1_used, id_rs2_used, id_regwrite, id_is_md;
   logic             ex_regwrite, ex_memread, md_start, ex_branch_taken, mem_stall;
   logic             pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble;
   logic             md_busy, md_wb;
   logic [REG_W-1:0] md_rd_q;
   logic [7:0]       outs_s;

   int errors = 0;
   int checks = 0;

   string      nm_q[$];
   logic [7:0] exp_q[$];

   hazard_ctrl #(.REG_W(REG_W), .MD_LAT(MD_LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_md(id_is_md),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .md_start(md_start), .md_rd(md_rd),
      .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
      .md_busy(md_busy), .md_wb(md_wb), .md_rd_q(md_rd_q)
   );

   assign outs_s = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, md_busy, md_wb};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Protocol: a new mul/div may only issue when idle or in the write-back cycle
   always @(negedge clk) begin
      if (rst_n && md_start && md_busy && !md_wb) begin
         errors++;
         $display("FAIL md_protocol: md_start while busy at %0t", $time);
      end
   end

   typedef struct packed {
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] exrd;
      logic       exrw;
      logic       exmr;
      logic       br;
      logic       ms;
      logic [5:0] exp;
   } vec_t;

   localparam int NV = 11;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                               input logic u2, input logic [4:0] exrd, input logic exrw,
                               input logic exmr, input logic br, input logic ms,
                               input logic [5:0] exp);
      vec_t v;
      v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.exrd = exrd;
      v.exrw = exrw; v.exmr = exmr; v.br = br; v.ms = ms; v.exp = exp;
      return v;
   endfunction

   task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
      id_rd = 5'd0; id_regwrite = 1'b0; id_is_md = 1'b0;
      ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
      md_start = 1'b0; md_rd = 5'd0; ex_branch_taken = 1'b0; mem_stall = 1'b0;
   endtask

   // Inputs are already driven; expectation is queued, then compared mid-cycle
   task automatic step(input string nm, input logic [7:0] e);
      string      n;
      logic [7:0] x;
      nm_q.push_back(nm);
      exp_q.push_back(e);
      @(negedge clk);
      n = nm_q.pop_front();
      x = exp_q.pop_front();
      check(n, outs_s, x);
      @(posedge clk);
      #1;
   endtask

   task automatic id_reads(input logic [4:0] r);
      id_rs1 = r; id_rs1_used = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      tbl[0]  = mk(5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NORM);
      tbl[1]  = mk(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, STALL);
      tbl[2]  = mk(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, NORM);
      tbl[3]  = mk(5'd0, 1'b1, 5'd1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, NORM);
      tbl[4]  = mk(5'd2, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, STALL);
      tbl[5]  = mk(5'd2, 1'b1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, NORM);
      tbl[6]  = mk(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, NORM);
      tbl[7]  = mk(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, FLUSH);
      tbl[8]  = mk(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, FREEZE);
      tbl[9]  = mk(5'd3, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, FREEZE);
      tbl[10] = mk(5'd3, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FLUSH);

      // Reset state and the not-yet-running cycle after release
      @(negedge clk);
      check("rst_outs", outs_s, 8'h00);
      check("rst_md_rd_q", {3'b000, md_rd_q}, 8'h00);
      rst_n = 1'b1;
      #1;
      check("run_off", outs_s, 8'h00);
      @(posedge clk);
      #1;

      // Combinational hazard vectors with the scoreboard idle
      for (int i = 0; i < NV; i++) begin
         idle();
         id_rs1 = tbl[i].rs1; id_rs1_used = tbl[i].u1;
         id_rs2 = tbl[i].rs2; id_rs2_used = tbl[i].u2;
         id_rd = 5'd6; id_regwrite = 1'b1;
         ex_rd = tbl[i].exrd; ex_regwrite = tbl[i].exrw; ex_memread = tbl[i].exmr;
         ex_branch_taken = tbl[i].br; mem_stall = tbl[i].ms;
         step($sformatf("tbl%0d", i), {tbl[i].exp, 2'b00});
      end

      // Mul/div to x7: RAW stall through DONE, unrelated x8 passes, WAW stalls, branch overrides
      idle(); md_start = 1'b1; md_rd = 5'd7;
      step("md1_issue", {NORM, 2'b00});
      check("md1_rd_q", {3'b000, md_rd_q}, 8'd7);
      for (int k = 1; k <= MD_LAT; k++) begin
         idle();
         if (k == 3) begin
            id_reads(5'd8);
            step($sformatf("md1_k%0d", k), {NORM, 1'b1, 1'b0});
         end else if (k == 4) begin
            id_rd = 5'd7; id_regwrite = 1'b1;
            step($sformatf("md1_k%0d", k), {STALL, 1'b1, 1'b0});
         end else if (k == 5) begin
            id_reads(5'd7); ex_branch_taken = 1'b1;
            step($sformatf("md1_k%0d", k), {FLUSH, 1'b1, 1'b0});
         end else begin
            id_reads(5'd7);
            step($sformatf("md1_k%0d", k), {STALL, 1'b1, (k == MD_LAT) ? 1'b1 : 1'b0});
         end
      end
      idle(); id_reads(5'd7);
      step("md1_release", {NORM, 2'b00});

      // Structural stall, then back-to-back issue in the write-back cycle
      idle(); md_start = 1'b1; md_rd = 5'd3;
      step("md2_issue", {NORM, 2'b00});
      for (int k = 1; k <= MD_LAT; k++) begin
         idle(); id_is_md = 1'b1;
         if (k == MD_LAT) begin
            md_start = 1'b1; md_rd = 5'd9;
         end else begin
            md_rd = 5'd0;
         end
         step($sformatf("md2_k%0d", k), {STALL, 1'b1, (k == MD_LAT) ? 1'b1 : 1'b0});
      end
      idle();
      check("md2_rd_q", {3'b000, md_rd_q}, 8'd9);
      for (int k = 1; k <= MD_LAT; k++) begin
         step($sformatf("md2b_k%0d", k), {NORM, 1'b1, (k == MD_LAT) ? 1'b1 : 1'b0});
      end
      step("md2_idle", {NORM, 2'b00});

      // Memory freeze during BUSY does not delay write-back
      idle(); md_start = 1'b1; md_rd = 5'd4;
      step("md3_issue", {NORM, 2'b00});
      for (int k = 1; k <= MD_LAT; k++) begin
         idle();
         mem_stall = (k >= 2 && k <= 4);
         step($sformatf("md3_k%0d", k),
              {(k >= 2 && k <= 4) ? FREEZE : NORM, 1'b1, (k == MD_LAT) ? 1'b1 : 1'b0});
      end
      idle();
      step("md3_idle", {NORM, 2'b00});

      // Reset in the middle of BUSY aborts the op
      idle(); md_start = 1'b1; md_rd = 5'd6;
      step("md4_issue", {NORM, 2'b00});
      idle();
      step("md4_k1", {NORM, 2'b10});
      step("md4_k2", {NORM, 2'b10});
      rst_n = 1'b0;
      #1;
      check("md4_rst_outs", outs_s, 8'h00);
      check("md4_rst_rd_q", {3'b000, md_rd_q}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("md4_run_off", outs_s, 8'h00);
      @(posedge clk);
      #1;
      for (int k = 1; k <= MD_LAT + 2; k++) begin
         step($sformatf("md4_after%0d", k), {NORM, 2'b00});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
